// File: rtl/regfile_ctrl_pkg.sv
// Shared types and defaults for the register-file controller and its arbiter.
// Selects are fixed at 3 bits, so the register count is expected to stay at 8.
package regfile_ctrl_pkg;

    localparam int NREGS_DEFAULT = 8;
    localparam int WIDTH_DEFAULT = 16;
    localparam int SEL_W         = 3;

    typedef logic [SEL_W-1:0] reg_sel_t;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } ctrl_state_t;

    typedef enum logic {
        GNT_WB0 = 1'b0,
        GNT_WB1 = 1'b1
    } wb_port_t;

endpackage

// File: rtl/regfile_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter. A grant is only ever given to a requester,
// so a grant is also a completed handshake and moves the last-grant pointer.
module rr_arb2
    import regfile_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    wb_port_t last_gnt;

    // On a conflict, the port that did not win last time wins now.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (enable) begin
            if (req0 && req1) begin
                if (last_gnt == GNT_WB1) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= GNT_WB1;
        end else if (gnt0) begin
            last_gnt <= GNT_WB0;
        end else if (gnt1) begin
            last_gnt <= GNT_WB1;
        end
    end

endmodule

// File: rtl/regfile_ctrl.sv
// Register-file controller: clears the external register file after reset, then
// arbitrates two write-back ports and gates operand issue with a busy scoreboard.
module regfile_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,

    output logic             rf_en,
    output logic             rf_we,
    output reg_sel_t         rf_sel_a,
    output reg_sel_t         rf_sel_b,
    output reg_sel_t         rf_sel_d,
    output logic [WIDTH-1:0] rf_data_d,
    input  logic [WIDTH-1:0] rf_data_out_a,
    input  logic [WIDTH-1:0] rf_data_out_b,

    input  logic             iss_valid,
    output logic             iss_ready,
    input  reg_sel_t         iss_src_a,
    input  reg_sel_t         iss_src_b,
    input  reg_sel_t         iss_dst,
    input  logic             iss_dst_en,

    output logic             op_valid,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,

    input  logic             wb0_valid,
    output logic             wb0_ready,
    input  reg_sel_t         wb0_sel,
    input  logic [WIDTH-1:0] wb0_data,

    input  logic             wb1_valid,
    output logic             wb1_ready,
    input  reg_sel_t         wb1_sel,
    input  logic [WIDTH-1:0] wb1_data,

    output logic [NREGS-1:0] busy
);

    localparam reg_sel_t LAST_REG = reg_sel_t'(NREGS - 1);

    ctrl_state_t      state;
    ctrl_state_t      state_next;
    reg_sel_t         clr_cnt;
    reg_sel_t         clr_cnt_next;
    logic             run;
    logic             gnt0;
    logic             gnt1;
    logic             wr_fire;
    reg_sel_t         wr_sel;
    logic [WIDTH-1:0] wr_data;
    logic             iss_fire;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;

    assign run   = (state == RUN);
    assign rf_en = rst_n;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (run),
        .req0   (wb0_valid),
        .req1   (wb1_valid),
        .gnt0   (gnt0),
        .gnt1   (gnt1)
    );

    assign wb0_ready = gnt0;
    assign wb1_ready = gnt1;
    assign wr_fire   = gnt0 | gnt1;
    assign wr_sel    = gnt1 ? wb1_sel  : wb0_sel;
    assign wr_data   = gnt1 ? wb1_data : wb0_data;

    // No bypass: a source being cleared this cycle still blocks issue.
    assign iss_ready = run && !busy[iss_src_a] && !busy[iss_src_b]
                       && !(iss_dst_en && busy[iss_dst]);
    assign iss_fire  = iss_valid && iss_ready;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (iss_fire && iss_dst_en) begin
            set_mask[iss_dst] = 1'b1;
        end
        if (wr_fire) begin
            clr_mask[wr_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    // CLEAR zeroes one register per cycle; RUN forwards the arbitration winner.
    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        rf_we        = 1'b0;
        rf_sel_d     = '0;
        rf_data_d    = '0;
        rf_sel_a     = '0;
        rf_sel_b     = '0;
        case (state)
            CLEAR: begin
                rf_we        = rst_n;
                rf_sel_d     = clr_cnt;
                clr_cnt_next = clr_cnt + 3'd1;
                if (clr_cnt == LAST_REG) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                rf_we     = wr_fire;
                rf_sel_d  = wr_sel;
                rf_data_d = wr_data;
                rf_sel_a  = iss_src_a;
                rf_sel_b  = iss_src_b;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    // A reservation overrides a same-cycle release of the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            op_valid <= 1'b0;
        end else begin
            busy     <= (busy & ~clr_mask) | set_mask;
            op_valid <= iss_fire;
        end
    end

    assign op_a = rf_data_out_a;
    assign op_b = rf_data_out_b;

endmodule

// File: doc/regfile_ctrl.md
REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 SHALL have parameter NREGS, default 8, meaning number of registers; the register-select width is 3 bits.
REQ-002 SHALL have parameter WIDTH, default 16, meaning register data width.
REQ-003 SHALL have ports clk, in, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have ports rst_n, in, 1, asynchronous active-low reset.
REQ-005 SHALL have ports rf_en, rf_we, out, 1 each, register-file enable and write enable.
REQ-006 SHALL have ports rf_sel_a, rf_sel_b, rf_sel_d, out, 3 each, register-file read and write selects.
REQ-007 SHALL have port rf_data_d, out, WIDTH, register-file write data.
REQ-008 SHALL have ports rf_data_out_a, rf_data_out_b, in, WIDTH each, register-file read data, valid one cycle after the selects.
REQ-009 SHALL have the issue port: iss_valid (in, 1); iss_ready (out, 1); iss_src_a, iss_src_b, iss_dst (in, 3 each); iss_dst_en (in, 1).
REQ-010 SHALL have operand outputs op_valid (out, 1) and op_a, op_b (out, WIDTH each).
REQ-011 SHALL have write port wb0 (ALU): wb0_valid (in, 1); wb0_ready (out, 1); wb0_sel (in, 3); wb0_data (in, WIDTH). Write port wb1 (load) SHALL be identical with the wb1_ prefix.
REQ-012 SHALL have busy, out, NREGS, scoreboard state for debug and monitoring.

Function
REQ-013 SHALL have states CLEAR and RUN, and SHALL enter CLEAR on reset.
REQ-014 In CLEAR, SHALL drive rf_we=1, rf_data_d=0 and rf_sel_d equal to a 3-bit counter running 0..7, one register per cycle, then go to RUN after the write to r7. CLEAR therefore takes exactly 8 cycles.
REQ-015 In CLEAR, SHALL hold iss_ready, wb0_ready and wb1_ready at 0.
REQ-016 SHALL hold rf_en at 1 whenever rst_n is high.
REQ-017 In RUN, SHALL perform at most one write per cycle. A write occurs on a valid&&ready handshake and drives rf_we=1 with the winner's sel and data to rf_sel_d and rf_data_d; otherwise rf_we=0.
REQ-018 Arbitration SHALL be round-robin. With only one port valid, that port is granted. With both valid, the port not granted last is granted. The last-grant pointer resets to wb1, so wb0 wins the first conflict.
REQ-019 ready for each wb port SHALL be combinational: ready = RUN && granted.
REQ-020 Scoreboard: busy[d] SHALL be set on an issue handshake with iss_dst_en=1, and busy[s] SHALL be cleared on any write to register s.
REQ-021 If a set and a clear hit the same register in the same cycle, the set SHALL win.
REQ-022 iss_ready SHALL equal RUN && !busy[src_a] && !busy[src_b] && !(iss_dst_en && busy[dst]). There is no bypass: a write clearing a source in the same cycle still stalls issue, which proceeds the next cycle.
REQ-023 rf_sel_a and rf_sel_b SHALL follow iss_src_a and iss_src_b combinationally in RUN, and SHALL be 0 in CLEAR.
REQ-024 op_valid SHALL be a register set to 1 the cycle after an issue handshake, 0 otherwise. op_a and op_b SHALL pass rf_data_out_a and rf_data_out_b through, so latency from issue to operands is 1 cycle.
REQ-025 A write to a non-busy register SHALL be performed normally with no scoreboard change.

Reset
REQ-026 On rst_n low, SHALL asynchronously set: state=CLEAR, clear counter=0, busy=0, op_valid=0 and the last-grant pointer to wb1.
REQ-027 While rst_n is low, combinational outputs SHALL be: rf_we=0, rf_en=0, all readies 0.
REQ-028 Reset mid-RUN or mid-CLEAR SHALL abandon in-flight reservations and SHALL restart the full 8-cycle CLEAR.

Structure
REQ-029 A shared package SHALL hold the NREGS and WIDTH defaults, a reg_sel_t 3-bit typedef and the ctrl_state_t enum {CLEAR, RUN}.
REQ-030 The round-robin two-port arbiter SHALL be a sub-module named rr_arb2.
REQ-031 The register file itself SHALL stay external and be connected through the rf_* ports.

Verification
REQ-032 Release reset -> rf_we=1 for 8 cycles with rf_sel_d 0..7 and rf_data_d 0; iss_ready rises in cycle 9.
REQ-033 Issue src_a=1, src_b=2, dst=3 after r1=0x1234 and r2=0xFAB5 are written -> next cycle op_valid=1, op_a=0x1234, op_b=0xFAB5, busy=8'h08.
REQ-034 Issue src_a=3 while busy[3] -> iss_ready=0. Then wb0 writes r3=0x00AA -> busy[3] clears, and the issue is accepted the following cycle with op_a=0x00AA.
REQ-035 wb0 and wb1 both valid for 4 cycles -> grants alternate wb0, wb1, wb0, wb1, and exactly one rf_we per cycle.
REQ-036 Same-cycle issue reserving r5 and wb1 writing r5 -> busy[5]=1 afterwards.
REQ-037 Assert rst_n low mid-RUN with busy=8'hFF -> busy=0 immediately, then a full 8-cycle CLEAR repeats.
